// File: rtl/poly_wave_synth.sv
// Time-multiplexed polyphonic oscillator/mixer: one voice per cycle through a
// two-stage waveform/MAC pipeline, saturating mix, then an optional one-pole IIR low-pass.
module poly_wave_synth #(
    parameter int N_VOICES = 8,
    parameter int PHASE_W  = 32,
    parameter int VOL_W    = 8,
    parameter int OUT_W    = 16,
    parameter int CUTOFF_W = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sample_tick,
    input  logic [N_VOICES-1:0][PHASE_W-1:0]   phase_incs,
    input  logic [N_VOICES-1:0][VOL_W-1:0]     volumes,
    input  logic [N_VOICES-1:0][1:0]           waveforms,
    input  logic                               filter_enabled,
    input  logic [CUTOFF_W-1:0]                cutoff,
    output logic [OUT_W-1:0]                   out,
    output logic                               out_valid,
    output logic                               busy,
    output logic                               overrun,
    output logic [2:0]                         dbg_state
);
    localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W  = OUT_W + VOL_W + $clog2(N_VOICES) + 1;
    localparam int Y_W    = OUT_W + 8;
    localparam int M      = PHASE_W - 1;

    localparam logic signed [OUT_W-1:0] H_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] H_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(H_POS);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(H_NEG);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_MIX, S_FILTER} state_t;

    state_t state, state_next;
    logic   start;

    logic [VIDX_W-1:0]        vidx, s2_idx;
    logic                     s2_valid;
    logic [PHASE_W-1:0]       phase [N_VOICES];
    logic signed [OUT_W-1:0]  w_reg, m_reg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [Y_W-1:0]    y;

    logic [PHASE_W-1:0]            p_new;
    logic signed [OUT_W-1:0]       w_new;
    logic signed [OUT_W+VOL_W:0]   prod;
    logic signed [ACC_W-1:0]       acc_sh;
    logic signed [OUT_W-1:0]       m_sat;
    logic [CUTOFF_W:0]             k;
    logic signed [Y_W:0]           diff, shifted;
    logic signed [Y_W-1:0]         y_new;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            S_IDLE: if (sample_tick) begin
                state_next = S_RUN;
                start      = 1'b1;
            end
            S_RUN:    if (vidx == VIDX_W'(N_VOICES - 1)) state_next = S_DRAIN;
            S_DRAIN:  state_next = S_MIX;
            S_MIX:    state_next = S_FILTER;
            S_FILTER: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Stage 1: advance the current voice's phase and shape it from the new phase.
    always_comb begin
        p_new = phase[vidx] + phase_incs[vidx];
        w_new = '0;
        case (waveforms[vidx])
            2'd0: w_new = p_new[M] ? H_NEG : H_POS;
            2'd1: w_new = p_new[M -: OUT_W] ^ H_NEG;
            2'd2: w_new = (p_new[M] ? ~p_new[M-1 -: OUT_W] : p_new[M-1 -: OUT_W]) ^ H_NEG;
            default: w_new = '0;
        endcase
    end

    always_comb begin
        prod   = w_reg * $signed({1'b0, volumes[s2_idx]});
        acc_sh = acc >>> VOL_W;
        if (acc_sh > SAT_MAX)      m_sat = H_POS;
        else if (acc_sh < SAT_MIN) m_sat = H_NEG;
        else                       m_sat = acc_sh[OUT_W-1:0];
        k       = {1'b0, cutoff} + {{CUTOFF_W{1'b0}}, 1'b1};
        diff    = (Y_W+1)'($signed({m_reg, 8'd0})) - (Y_W+1)'(y);
        shifted = diff >>> k;
        y_new   = Y_W'((Y_W+1)'(y) + shifted);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_VOICES; i++) phase[i] <= '0;
            vidx      <= '0;
            s2_idx    <= '0;
            s2_valid  <= 1'b0;
            w_reg     <= '0;
            m_reg     <= '0;
            acc       <= '0;
            y         <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            s2_valid  <= 1'b0;
            if (sample_tick && busy) overrun <= 1'b1;
            if (start) begin
                acc  <= '0;
                vidx <= '0;
            end
            if (state == S_RUN) begin
                phase[vidx] <= p_new;
                w_reg       <= w_new;
                s2_idx      <= vidx;
                s2_valid    <= 1'b1;
                vidx        <= vidx + 1'b1;
            end
            // Stage 2 trails stage 1 by one cycle; the last voice lands in DRAIN.
            if (s2_valid) acc <= acc + ACC_W'(prod);
            if (state == S_MIX) m_reg <= m_sat;
            if (state == S_FILTER) begin
                y         <= y_new;
                out       <= filter_enabled ? y_new[Y_W-1:8] : m_reg;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_poly_wave_synth.sv
// Directed bench for poly_wave_synth: hand-computed samples, frame timing,
// overrun stickiness, filter response and mid-frame reset.
module tb_poly_wave_synth;
    localparam int N = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  sample_tick = 1'b0;
    logic [N-1:0][31:0]    phase_incs;
    logic [N-1:0][7:0]     volumes;
    logic [N-1:0][1:0]     waveforms;
    logic                  filter_enabled = 1'b0;
    logic [2:0]            cutoff = 3'd0;
    logic signed [15:0]    out_s;
    logic                  out_valid;
    logic                  busy;
    logic                  overrun;
    logic [2:0]            dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    poly_wave_synth dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .phase_incs(phase_incs), .volumes(volumes), .waveforms(waveforms),
        .filter_enabled(filter_enabled), .cutoff(cutoff),
        .out(out_s), .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic config_voices(input int n_active, input logic [1:0] wf,
                                 input logic [31:0] inc, input logic [7:0] vol);
        for (int i = 0; i < N; i++) begin
            phase_incs[i] = (i < n_active) ? inc : 32'd0;
            volumes[i]    = (i < n_active) ? vol : 8'd0;
            waveforms[i]  = (i < n_active) ? wf  : 2'd3;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Tick in cycle 0, then observe cycles 1..14; returns sample and out_valid count.
    task automatic do_frame(output int val, output int nvalid);
        nvalid = 0;
        val = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid) begin
                nvalid++;
                val = int'(out_s);
            end
        end
    endtask

    task automatic frame_check(input string tag, input int exp);
        int v, nv;
        do_frame(v, nv);
        check({tag, "_valid_cnt"}, nv, 1);
        check(tag, v, exp);
    endtask

    int exp5 [9] = '{-16320, 0, 16320, 32639, 16319, -1, -16321, -32640, -16320};
    int nv;

    initial begin
        config_voices(1, 2'd0, 32'h4000_0000, 8'd255);

        // Reset state
        do_reset();
        check("rst_out", int'(out_s), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_state", int'(dbg_state), 0);

        // Single square voice
        frame_check("t1_tick1", 32639);
        frame_check("t1_tick2", -32640);
        frame_check("t1_tick3", -32640);

        // Eight square voices, saturating both ways
        do_reset();
        config_voices(8, 2'd0, 32'h4000_0000, 8'd255);
        frame_check("t2_tick1", 32767);
        frame_check("t2_tick2", -32768);

        // Frame timing and overrun
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        nv = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("t3_busy_c%0d", c), int'(busy), (c <= 11) ? 1 : 0);
            check($sformatf("t3_valid_c%0d", c), int'(out_valid), (c == 12) ? 1 : 0);
            if (out_valid) nv++;
            sample_tick = (c == 5);
        end
        check("t3_valid_cnt", nv, 1);
        check("t3_overrun", int'(overrun), 1);
        frame_check("t3_after", 32767);
        check("t3_overrun_sticky", int'(overrun), 1);
        do_reset();
        check("t3_overrun_cleared", int'(overrun), 0);

        // Saw through the low-pass, then bypass
        config_voices(1, 2'd1, 32'h0, 8'd255);
        filter_enabled = 1'b1;
        cutoff = 3'd0;
        frame_check("t4_f1", -16320);
        frame_check("t4_f2", -24480);
        frame_check("t4_f3", -28560);
        filter_enabled = 1'b0;
        frame_check("t4_bypass", -32640);

        // Triangle over a full phase cycle and wrap
        do_reset();
        config_voices(1, 2'd2, 32'h2000_0000, 8'd255);
        for (int t = 0; t < 9; t++)
            frame_check($sformatf("t5_tick%0d", t + 1), exp5[t]);

        // Reset mid-frame
        do_reset();
        config_voices(1, 2'd0, 32'h4000_0000, 8'd255);
        frame_check("t6_pre", 32639);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("t6_no_valid", nv, 0);
        check("t6_out_zero", int'(out_s), 0);
        check("t6_busy", int'(busy), 0);
        frame_check("t6_restart", 32639);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
